// File: rtl/ax_level_controller.sv
// Approximation-level controller: arbitrates CSR/external level requests, drains the
// pipeline before applying a change and enforces a hold-off. Optional clamp: RSD_AX_LEVEL_CLAMP_EN.
module ax_level_controller #(
    parameter int AX_LEVEL_WIDTH = 4,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int RESET_LEVEL    = 0,
    parameter int MAX_LEVEL      = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      csrLevelEn,
    input  logic [AX_LEVEL_WIDTH-1:0] csrLevelData,
    input  logic                      extLevelEn,
    input  logic [AX_LEVEL_WIDTH-1:0] extLevelData,
    input  logic                      quiesceAck,
    output logic                      quiesceReq,
    output logic [AX_LEVEL_WIDTH-1:0] axLevel,
    output logic                      levelChanged,
    output logic                      busy,
    output logic [15:0]               lastDrainCycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [AX_LEVEL_WIDTH-1:0] RESET_LVL = AX_LEVEL_WIDTH'(RESET_LEVEL);
    localparam logic [7:0]                HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

    state_t                      r_state;
    logic [AX_LEVEL_WIDTH-1:0]   r_ax_level;
    logic [AX_LEVEL_WIDTH-1:0]   r_pending;
    logic                        r_pending_valid;
    logic                        r_level_changed;
    logic [15:0]                 r_drain_cnt;
    logic [15:0]                 r_last_drain;
    logic [7:0]                  r_hold_cnt;

    logic                        w_req;
    logic [AX_LEVEL_WIDTH-1:0]   w_req_raw;
    logic [AX_LEVEL_WIDTH-1:0]   w_req_lvl;
    logic [AX_LEVEL_WIDTH-1:0]   w_eff_pend;
    logic                        w_hold_pv;
    logic [15:0]                 w_drain_next;

    // CSR strobe wins over the external pin on the same cycle
    assign w_req     = csrLevelEn | extLevelEn;
    assign w_req_raw = csrLevelEn ? csrLevelData : extLevelData;

`ifdef RSD_AX_LEVEL_CLAMP_EN
    localparam logic [AX_LEVEL_WIDTH-1:0] MAX_LVL = AX_LEVEL_WIDTH'(MAX_LEVEL);
    assign w_req_lvl = (w_req_raw > MAX_LVL) ? MAX_LVL : w_req_raw;
`else
    assign w_req_lvl = w_req_raw;
`endif

    // A request arriving on the deciding edge is treated as the latest pending value
    assign w_eff_pend   = w_req ? w_req_lvl : r_pending;
    assign w_hold_pv    = r_pending_valid | w_req;
    assign w_drain_next = (r_drain_cnt == 16'hFFFF) ? r_drain_cnt : r_drain_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_ax_level      <= RESET_LVL;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_level_changed <= 1'b0;
            r_drain_cnt     <= '0;
            r_last_drain    <= '0;
            r_hold_cnt      <= '0;
        end else begin
            r_level_changed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req && (w_req_lvl != r_ax_level)) begin
                        r_pending   <= w_req_lvl;
                        r_drain_cnt <= '0;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_drain_cnt <= w_drain_next;
                    if (quiesceAck) begin
                        r_pending_valid <= 1'b0;
                        if (w_eff_pend != r_ax_level) begin
                            r_ax_level      <= w_eff_pend;
                            r_level_changed <= 1'b1;
                            r_last_drain    <= w_drain_next;
                            r_hold_cnt      <= HOLD_LOAD;
                            r_state         <= HOLD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_pending <= w_eff_pend;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == 8'd0) begin
                        r_pending_valid <= 1'b0;
                        if (w_hold_pv && (w_eff_pend != r_ax_level)) begin
                            r_pending   <= w_eff_pend;
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                        if (w_req) begin
                            r_pending_valid <= 1'b1;
                            r_pending       <= w_req_lvl;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign quiesceReq      = (r_state == DRAIN);
    assign busy            = (r_state != IDLE);
    assign axLevel         = r_ax_level;
    assign levelChanged    = r_level_changed;
    assign lastDrainCycles = r_last_drain;

endmodule

// File: doc/ax_level_controller.md
AX_LEVEL_CONTROLLER -- requirements
Module: ax_level_controller

Interface
REQ-001 SHALL have parameter AX_LEVEL_WIDTH, default 4, giving the approximation-level width in bits.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 16, giving the minimum cycles between level changes (1..255).
REQ-003 SHALL have parameter RESET_LEVEL, default 0, giving the axLevel value after reset.
REQ-004 SHALL have parameter MAX_LEVEL, default 7, giving the highest legal level (used only under the config macro).
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 csrLevelEn  in  1  CSR-side level write strobe.
REQ-008 csrLevelData  in  AX_LEVEL_WIDTH  CSR-requested level.
REQ-009 extLevelEn  in  1  external-pin level write strobe.
REQ-010 extLevelData  in  AX_LEVEL_WIDTH  externally requested level.
REQ-011 quiesceAck  in  1  pipeline reports no in-flight approximate ops.
REQ-012 quiesceReq  out  1  request to stop issuing approximate ops.
REQ-013 axLevel  out  AX_LEVEL_WIDTH  active level to fetch/DCache/branch deciders.
REQ-014 levelChanged  out  1  one-cycle pulse when axLevel updates.
REQ-015 busy  out  1  high when state is not IDLE.
REQ-016 lastDrainCycles  out  16  cycles spent in DRAIN for the last applied change (saturating).

Function
REQ-017 SHALL implement states IDLE, DRAIN and HOLD, all registered; quiesceReq = (state==DRAIN); busy = (state!=IDLE).
REQ-018 Same-cycle arbitration SHALL be fixed priority: the CSR request beats the external request.
REQ-019 In IDLE, a winning request whose level differs from axLevel SHALL latch pending and move to DRAIN next cycle; a request equal to axLevel SHALL be ignored.
REQ-020 In DRAIN, a new winning request SHALL overwrite pending (latest wins).
REQ-021 In DRAIN with quiesceAck=1, the controller SHALL load axLevel from pending on that edge, pulse levelChanged in the following cycle, and enter HOLD.
REQ-022 If pending equals axLevel when quiesceAck arrives, the controller SHALL go to IDLE without a levelChanged pulse.
REQ-023 The drain counter SHALL clear on entry to DRAIN, increment each DRAIN cycle and saturate at 16'hFFFF; lastDrainCycles SHALL update only on an applied change.
REQ-024 HOLD SHALL last exactly HOLDOFF_CYCLES cycles, counted by a down-counter loaded on entry.
REQ-025 Requests during HOLD SHALL set pendingValid and pending (latest wins, CSR priority).
REQ-026 When HOLD ends, the controller SHALL go to DRAIN if pendingValid and pending!=axLevel, else to IDLE; pendingValid SHALL clear.
REQ-027 quiesceAck outside DRAIN SHALL be ignored.
REQ-028 Request-to-quiesceReq latency SHALL be 1 cycle; quiesceAck-to-axLevel latency SHALL be 1 cycle.

Reset
REQ-029 While rst=0 on an edge: state=IDLE, axLevel=RESET_LEVEL, quiesceReq=0, levelChanged=0, busy=0, lastDrainCycles=0, pendingValid=0, all counters 0.
REQ-030 Reset mid-DRAIN or mid-HOLD SHALL discard pending and take effect on that same edge.

Configuration
REQ-031 Macro RSD_AX_LEVEL_CLAMP_EN: when defined, any requested level above MAX_LEVEL SHALL be clamped to MAX_LEVEL before the comparison and the latch.
REQ-032 Without RSD_AX_LEVEL_CLAMP_EN, requested levels SHALL pass unmodified and MAX_LEVEL is unused.

Verification
REQ-033 Reset, then csrLevelEn with data 3 at cycle 10, quiesceAck at cycle 14 -> quiesceReq high in cycles 11-14, axLevel=3 from cycle 15, levelChanged pulse in cycle 15, lastDrainCycles=4.
REQ-034 csrLevelEn with data 2 and extLevelEn with data 5 in the same cycle from IDLE -> pending=2; after ack axLevel=2.
REQ-035 axLevel=3, ext request 6 during HOLD cycle 5 of 16 -> stays in HOLD all 16 cycles, then DRAIN; after ack axLevel=6.
REQ-036 Request 4 in IDLE, rst=0 while in DRAIN, then quiesceAck -> axLevel=RESET_LEVEL, no levelChanged, busy=0.
REQ-037 With RSD_AX_LEVEL_CLAMP_EN and MAX_LEVEL=7, request 12 -> axLevel=7; without the macro -> axLevel=12.
REQ-038 Request equal to the current axLevel in IDLE -> no DRAIN and quiesceReq stays 0.
